// File: rtl/mux3_seq_ctrl_pkg.sv
// Shared encodings for the operand-mux sequencer: FSM states and the mux select codes.
// The select codes are also used by the registered 3-input operand mux.
package mux3_seq_ctrl_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL_A,
    S_SEL_B,
    S_SEL_C,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_A    = 2'b01;
  localparam logic [1:0] SEL_B    = 2'b10;
  localparam logic [1:0] SEL_C    = 2'b11;

  // True in the states that drive an operand onto the mux.
  function automatic logic is_sel_state(state_t s);
    return (s == S_SEL_A) || (s == S_SEL_B) || (s == S_SEL_C);
  endfunction

endpackage

// File: rtl/mux3_seq_ctrl_if.sv
// Start/busy/done handshake plus mux control between the top-level controller and the sequencer.
// master = controller side, slave = sequencer side.
interface mux3_seq_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] n_pass;
  logic [1:0]       select;
  logic             acc_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pass_cnt;

  modport master (
    output start, abort, n_pass,
    input  select, acc_en, busy, done, pass_cnt
  );

  modport slave (
    input  start, abort, n_pass,
    output select, acc_en, busy, done, pass_cnt
  );
endinterface

// File: rtl/mux3_seq_ctrl.sv
// Runs n_pass A/B/C passes on the operand-mux select; acc_en trails select by one cycle (mux latency).
// All outputs registered; start is honoured only in IDLE, abort cancels any run without a done pulse.
module mux3_seq_ctrl
  import mux3_seq_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  mux3_seq_ctrl_if.slave ctrl
);

  state_t           state;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] pcnt_inc;
  logic [1:0]       sel_q;
  logic             acc_q;
  logic             busy_q;
  logic             done_q;

  assign pcnt_inc = pcnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      n_lat  <= '0;
      pcnt   <= '0;
      sel_q  <= SEL_HOLD;
      acc_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      // The mux registers the operand on this edge, so its output is valid next cycle.
      acc_q <= is_sel_state(state);

      if (ctrl.abort) begin
        state  <= S_IDLE;
        sel_q  <= SEL_HOLD;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (ctrl.start) begin
              n_lat  <= ctrl.n_pass;
              pcnt   <= '0;
              busy_q <= 1'b1;
              if (ctrl.n_pass != '0) begin
                state <= S_SEL_A;
                sel_q <= SEL_A;
              end else begin
                state  <= S_DONE;
                done_q <= 1'b1;
              end
            end
          end
          S_SEL_A: begin
            state <= S_SEL_B;
            sel_q <= SEL_B;
          end
          S_SEL_B: begin
            state <= S_SEL_C;
            sel_q <= SEL_C;
          end
          S_SEL_C: begin
            pcnt <= pcnt_inc;
            if (pcnt_inc == n_lat) begin
              state <= S_DRAIN;
              sel_q <= SEL_HOLD;
            end else begin
              state <= S_SEL_A;
              sel_q <= SEL_A;
            end
          end
          S_DRAIN: begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end
          S_DONE: begin
            state  <= S_IDLE;
            done_q <= 1'b0;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            sel_q  <= SEL_HOLD;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ctrl.select   = sel_q;
  assign ctrl.acc_en   = acc_q;
  assign ctrl.busy     = busy_q;
  assign ctrl.done     = done_q;
  assign ctrl.pass_cnt = pcnt;

endmodule
